// File: rtl/la_cellcheck6.sv
// la_cellcheck6: stimulus/response checker for six-input, single-output library cells.
// Walks all 64 input vectors, holds each for SETTLE+1 cycles, samples the cell output
// at the end of the hold window and compares it against a golden truth table.
module la_cellcheck6 #(
  parameter              PROP   = "DEFAULT",
  parameter logic [63:0] TRUTH  = 64'hFF80_8080_8080_8080,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic            i_clk,
  input  logic            i_nreset,
  input  logic            i_start,
  output logic [5:0]      o_vec,
  input  logic            i_z,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [ERRW-1:0] o_errcount,
  output logic [5:0]      o_firstfail,
  output logic            o_firstfail_vld
);

  // Settle counter needs at least one bit even when SETTLE is 0.
  localparam int unsigned    CntW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE);
  localparam logic [ERRW-1:0] ErrMax = {ERRW{1'b1}};

  // PROP is an implementation tag only; it carries no logic.
  if ($bits(PROP) == 0) begin : g_no_prop
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]      r_vec, w_vec_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pass, w_pass_nxt;
  logic [ERRW-1:0] r_err, w_err_nxt;
  logic [5:0]      r_ff, w_ff_nxt;
  logic            r_ffv, w_ffv_nxt;
  logic            w_mismatch;

  assign w_mismatch = (i_z != TRUTH[r_vec]);

  // State register: all outputs are registered, reset asynchronously.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ff    <= '0;
      r_ffv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_ff    <= w_ff_nxt;
      r_ffv   <= w_ffv_nxt;
    end
  end

  // Next-state: start launches a run from IDLE or DONE; RUN walks vectors and scores samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_ff_nxt    = r_ff;
    w_ffv_nxt   = r_ffv;
    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
          w_vec_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = '0;
          w_ff_nxt    = '0;
          w_ffv_nxt   = 1'b0;
        end
      end
      StRun: begin
        if (r_cnt != CntMax) begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end else begin
          // Last edge of the hold window: sample and score this vector.
          w_cnt_nxt = '0;
          if (w_mismatch) begin
            if (r_err != ErrMax) w_err_nxt = r_err + ERRW'(1);
            if (!r_ffv) begin
              w_ff_nxt  = r_vec;
              w_ffv_nxt = 1'b1;
            end
          end
          if (r_vec == 6'd63) begin
            w_state_nxt = StDone;
            w_vec_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            // Includes the final sample, which is not yet in r_err.
            w_pass_nxt  = (r_err == '0) && !w_mismatch;
          end else begin
            w_vec_nxt = r_vec + 6'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_vec           = r_vec;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_errcount      = r_err;
  assign o_firstfail     = r_ff;
  assign o_firstfail_vld = r_ffv;

endmodule

// File: tb/tb_la_cellcheck6.sv
// Bench for la_cellcheck6: three instances (SETTLE=2/ERRW=8, SETTLE=2/ERRW=4, SETTLE=0/ERRW=8)
// run side by side against a cell model on z, checked against an ao33 reference model.
module tb_la_cellcheck6;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] vec [3];
  logic       z [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [7:0] err [3];
  logic [3:0] err_b;
  logic [5:0] ff [3];
  logic       ffv [3];

  // 0: correct ao33, 1: stuck-at-0, 2: stuck-at-1, 3: ao33 with flipped vectors in flip
  int          z_mode = 0;
  logic [63:0] flip = '0;

  int errors = 0;
  int checks = 0;

  int t_vec [3][256];
  int t_done [3][256];
  int t_pass [3][256];
  int t_err [3][256];
  int t_ffv [3][256];
  int done_k [3];
  int busy_n [3];

  always #5 clk = ~clk;

  // ao33 from its definition: all of a0..a2 or all of b0..b2.
  function automatic logic golden(input int v);
    return ((v % 8) == 7) || ((v / 8) == 7);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  function automatic int errw_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cell
    assign z[g] = (z_mode == 0) ? golden(int'(vec[g])) :
                  (z_mode == 1) ? 1'b0 :
                  (z_mode == 2) ? 1'b1 :
                  (golden(int'(vec[g])) ^ flip[vec[g]]);
  end

  assign err[1] = {4'b0000, err_b};

  la_cellcheck6 #(.SETTLE(2), .ERRW(8)) u_a (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .o_vec(vec[0]), .i_z(z[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_errcount(err[0]),
    .o_firstfail(ff[0]), .o_firstfail_vld(ffv[0])
  );

  la_cellcheck6 #(.SETTLE(2), .ERRW(4)) u_b (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .o_vec(vec[1]), .i_z(z[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_errcount(err_b),
    .o_firstfail(ff[1]), .o_firstfail_vld(ffv[1])
  );

  la_cellcheck6 #(.SETTLE(0), .ERRW(8)) u_c (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .o_vec(vec[2]), .i_z(z[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]), .o_errcount(err[2]),
    .o_firstfail(ff[2]), .o_firstfail_vld(ffv[2])
  );

  // Reference: score every vector of the current cell model against ao33.
  task automatic model_run(input int errw, output int errs, output int ff_o, output int ffv_o);
    int zv;
    errs  = 0;
    ff_o  = 0;
    ffv_o = 0;
    for (int v = 0; v < 64; v++) begin
      case (z_mode)
        0:       zv = int'(golden(v));
        1:       zv = 0;
        2:       zv = 1;
        default: zv = int'(golden(v) ^ flip[v]);
      endcase
      if (zv != int'(golden(v))) begin
        if (errs < (1 << errw) - 1) errs++;
        if (ffv_o == 0) begin
          ff_o  = v;
          ffv_o = 1;
        end
      end
    end
  endtask

  // Pulse start, then record outputs at each negedge k = 1..max_k after the start edge.
  // k = restart_k drives start high for one more cycle.
  task automatic run_record(input int max_k, input int restart_k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      done_k[i] = -1;
      busy_n[i] = 0;
    end
    for (int k = 1; k <= max_k; k++) begin
      start = (k == restart_k);
      for (int i = 0; i < 3; i++) begin
        t_vec[i][k]  = int'(vec[i]);
        t_done[i][k] = int'(done[i]);
        t_pass[i][k] = int'(pass[i]);
        t_err[i][k]  = int'(err[i]);
        t_ffv[i][k]  = int'(ffv[i]);
        if (done[i] && done_k[i] < 0) done_k[i] = k;
        if (busy[i]) busy_n[i]++;
      end
      if (k < max_k) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vec[i], busy[i], done[i], pass[i], err[i], ff[i], ffv[i]} !== 24'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d ffv=%0b, expected all 0",
                 i, vec[i], busy[i], done[i], pass[i], err[i], ff[i], ffv[i]);
      end
    end
  endtask

  task automatic test_correct();
    int n, bad, ev;
    z_mode = 0;
    run_record(200, 0);
    for (int i = 0; i < 3; i++) begin
      n = 64 * (settle_of(i) + 1);
      checks++;
      if (done_k[i] != n + 1) begin
        errors++;
        $display("FAIL correct_done_time inst%0d: got k=%0d, expected k=%0d", i, done_k[i], n + 1);
      end
      checks++;
      if (busy_n[i] != n) begin
        errors++;
        $display("FAIL correct_busy_cycles inst%0d: got %0d, expected %0d", i, busy_n[i], n);
      end
      bad = 0;
      for (int k = 1; k <= n + 3; k++) begin
        ev = (k <= n) ? (k - 1) / (settle_of(i) + 1) : 0;
        if (t_vec[i][k] != ev) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL correct_vec_sequence inst%0d: got %0d wrong cycles, expected 0", i, bad);
      end
      checks++;
      if ({pass[i], err[i], ffv[i]} !== {1'b1, 8'd0, 1'b0}) begin
        errors++;
        $display("FAIL correct_result inst%0d: got pass=%0b err=%0d ffv=%0b, expected pass=1 err=0 ffv=0",
                 i, pass[i], err[i], ffv[i]);
      end
    end
  endtask

  task automatic test_stuck_at();
    int e, f, fv;
    for (int m = 1; m <= 2; m++) begin
      z_mode = m;
      run_record(200, 0);
      for (int i = 0; i < 3; i++) begin
        model_run(errw_of(i), e, f, fv);
        checks++;
        if (int'(err[i]) != e || int'(ff[i]) != f || int'(ffv[i]) != fv ||
            pass[i] !== 1'b0 || done[i] !== 1'b1) begin
          errors++;
          $display("FAIL stuck%0d inst%0d: got err=%0d ff=%0d ffv=%0b pass=%0b done=%0b, expected err=%0d ff=%0d ffv=%0d pass=0 done=1",
                   m - 1, i, err[i], ff[i], ffv[i], pass[i], done[i], e, f, fv);
        end
      end
    end
  endtask

  task automatic test_random();
    int e, f, fv;
    for (int it = 0; it < 4; it++) begin
      z_mode = 3;
      if (it % 2 == 0) flip = {$urandom, $urandom};
      else flip = (64'd1 << $urandom_range(63, 0)) | (64'd1 << $urandom_range(63, 0));
      run_record(200, 0);
      for (int i = 0; i < 3; i++) begin
        model_run(errw_of(i), e, f, fv);
        checks++;
        if (int'(err[i]) != e || int'(ffv[i]) != fv || (fv == 1 && int'(ff[i]) != f) ||
            pass[i] !== (e == 0)) begin
          errors++;
          $display("FAIL random%0d inst%0d: got err=%0d ff=%0d ffv=%0b pass=%0b, expected err=%0d ff=%0d ffv=%0d pass=%0b",
                   it, i, err[i], ff[i], ffv[i], pass[i], e, f, fv, e == 0);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int e, f, fv;
    z_mode = 2;
    // k=61 is mid-run for every instance (vector 20 for SETTLE=2).
    run_record(200, 61);
    for (int i = 0; i < 3; i++) begin
      model_run(errw_of(i), e, f, fv);
      checks++;
      if (done_k[i] != 64 * (settle_of(i) + 1) + 1 || int'(err[i]) != e || int'(ff[i]) != f) begin
        errors++;
        $display("FAIL restart_ignored inst%0d: got done_k=%0d err=%0d ff=%0d, expected done_k=%0d err=%0d ff=%0d",
                 i, done_k[i], err[i], ff[i], 64 * (settle_of(i) + 1) + 1, e, f);
      end
    end
  endtask

  task automatic test_done_restart();
    int e, f, fv;
    z_mode = 1;
    run_record(200, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (t_err[i][1] != 0 || t_ffv[i][1] != 0 || t_done[i][1] != 0 || t_pass[i][1] != 0) begin
        errors++;
        $display("FAIL done_restart_clear inst%0d: got err=%0d ffv=%0d done=%0d pass=%0d, expected all 0",
                 i, t_err[i][1], t_ffv[i][1], t_done[i][1], t_pass[i][1]);
      end
      model_run(errw_of(i), e, f, fv);
      checks++;
      if (int'(err[i]) != e || int'(ff[i]) != f || done[i] !== 1'b1) begin
        errors++;
        $display("FAIL done_restart_final inst%0d: got err=%0d ff=%0d done=%0b, expected err=%0d ff=%0d done=1",
                 i, err[i], ff[i], done[i], e, f);
      end
    end
  endtask

  task automatic test_async_reset();
    int e, f, fv;
    z_mode = 1;
    run_record(91, 0);
    checks++;
    if (vec[0] !== 6'd30 || err[0] === 8'd0) begin
      errors++;
      $display("FAIL reset_midrun_pre: got vec=%0d err=%0d, expected vec=30 err>0", vec[0], err[0]);
    end
    #1 nreset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vec[i], busy[i], done[i], pass[i], err[i], ff[i], ffv[i]} !== 24'd0) begin
        errors++;
        $display("FAIL reset_async inst%0d: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d ffv=%0b, expected all 0",
                 i, vec[i], busy[i], done[i], pass[i], err[i], ff[i], ffv[i]);
      end
    end
    @(negedge clk);
    nreset = 1'b1;
    z_mode = 3;
    flip   = (64'd1 << $urandom_range(63, 0));
    run_record(200, 0);
    for (int i = 0; i < 3; i++) begin
      model_run(errw_of(i), e, f, fv);
      checks++;
      if (t_vec[i][1] != 0 || done_k[i] != 64 * (settle_of(i) + 1) + 1 ||
          int'(err[i]) != e || int'(ff[i]) != f || pass[i] !== (e == 0)) begin
        errors++;
        $display("FAIL reset_rerun inst%0d: got vec1=%0d done_k=%0d err=%0d ff=%0d pass=%0b, expected vec1=0 done_k=%0d err=%0d ff=%0d pass=%0b",
                 i, t_vec[i][1], done_k[i], err[i], ff[i], pass[i],
                 64 * (settle_of(i) + 1) + 1, e, f, e == 0);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    nreset = 1'b1;
    test_correct();
    test_stuck_at();
    test_random();
    test_restart_ignored();
    test_done_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
